// File: rtl/branch_predict_ctrl_if.sv
// branch_predict_ctrl_if: fetch lookup, EX resolve and counter signals of the branch predictor
interface branch_predict_ctrl_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredE;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;
  modport master (
    output PCF, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE, PredTargetE, StallE,
    input  PredTakenF, PredTargetF, MispredE, RedirectPC, BranchCnt, MispredCnt
  );
  modport slave (
    input  PCF, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE, PredTargetE, StallE,
    output PredTakenF, PredTargetF, MispredE, RedirectPC, BranchCnt, MispredCnt
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: direct-mapped BTB with 2-bit counters, EX training, mispredict redirect and counters
module branch_predict_ctrl #(
  parameter int ENTRY_BITS = 6,
  parameter int TAG_BITS   = 32 - ENTRY_BITS - 2
) (
  input logic CPU_CLK,
  input logic CPU_RST,
  branch_predict_ctrl_if.slave bp
);
  localparam int N = 1 << ENTRY_BITS;
  logic                  valid  [N];
  logic [TAG_BITS-1:0]   tag    [N];
  logic [31:0]           target [N];
  logic [1:0]            ctr    [N];
  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  res_e, mis_e, hit_e;
  assign idx_f = bp.PCF[ENTRY_BITS+1:2];
  assign tag_f = bp.PCF[31:ENTRY_BITS+2];
  assign idx_e = bp.PCE[ENTRY_BITS+1:2];
  assign tag_e = bp.PCE[31:ENTRY_BITS+2];
  // fetch lookup and EX mispredict detection, all forced quiet while in reset
  always_comb begin
    res_e          = (bp.BranchTypeE != 3'd0) && !bp.StallE;
    mis_e          = res_e && ((bp.BranchE != bp.PredTakenE) ||
                     (bp.BranchE && bp.PredTakenE && (bp.PredTargetE != bp.BrTargetE)));
    hit_e          = valid[idx_e] && (tag[idx_e] == tag_e);
    bp.PredTakenF  = !CPU_RST && valid[idx_f] && (tag[idx_f] == tag_f) && ctr[idx_f][1];
    bp.PredTargetF = bp.PredTakenF ? target[idx_f] : 32'd0;
    bp.MispredE    = !CPU_RST && mis_e;
    bp.RedirectPC  = !bp.MispredE ? 32'd0 : bp.BranchE ? bp.BrTargetE : bp.PCE + 32'd4;
  end
  // table training on resolved branches plus event counters; reset overrides training
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      for (int k = 0; k < N; k++) begin
        valid[k]  <= 1'b0;
        tag[k]    <= '0;
        target[k] <= '0;
        ctr[k]    <= 2'b01;
      end
      bp.BranchCnt  <= '0;
      bp.MispredCnt <= '0;
    end else if (res_e) begin
      bp.BranchCnt <= bp.BranchCnt + 32'd1;
      if (mis_e) bp.MispredCnt <= bp.MispredCnt + 32'd1;
      if (hit_e) begin
        if (bp.BranchE) begin
          ctr[idx_e]    <= (ctr[idx_e] == 2'b11) ? 2'b11 : ctr[idx_e] + 2'd1;
          target[idx_e] <= bp.BrTargetE;
        end else begin
          ctr[idx_e]    <= (ctr[idx_e] == 2'b00) ? 2'b00 : ctr[idx_e] - 2'd1;
        end
      end else if (bp.BranchE) begin
        valid[idx_e]  <= 1'b1;
        tag[idx_e]    <= tag_e;
        target[idx_e] <= bp.BrTargetE;
        ctr[idx_e]    <= 2'b10;
      end
    end
  end
endmodule
